// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/capture controller that sits in front of the 32-bit ALU. It accepts a
// decoded instruction (opcode/funct3/funct7) plus operand values over a
// valid/ready handshake and decodes them into the ALU 4-bit select code. It
// presents registered operands to the ALU, captures the result and flags one
// cycle later, and offers them to the consumer over a second valid/ready
// handshake.
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN
//   defined   : illegal instructions issue a = b = 0 with select AND. They
//               return result 0 / zero 1 / overflow 0 / carry 0, and raise
//               'illegal' while the result is offered.
//   undefined : 'illegal' is tied low. Illegal instructions issue select AND
//               with a = rs1_val and b = rs2_val.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   instruction handshake
//   opcode/funct3/funct7 instruction fields
//   rs1_val/rs2_val/imm operand sources
//   alu_a/alu_b/alu_sel registered ALU operands and select code
//   alu_out/alu_zero/alu_ovf/alu_cout  ALU result and flags
//   out_valid/out_ready result handshake
//   result/zero/overflow/carry  captured ALU result and flags
//   illegal             undecodable instruction flag (see macro)
// -----------------------------------------------------------------------------
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        carry,
  output logic        illegal
);

  // ALU select codes
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
  localparam logic [3:0] SEL_EQ  = 4'b1111;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_reg, state_next;

  logic [31:0] alu_a_reg, alu_b_reg;
  logic [3:0]  alu_sel_reg;
  logic [31:0] result_reg;
  logic        zero_reg, overflow_reg, carry_reg;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [3:0] dec_sel;
  logic       dec_use_imm;
  logic       dec_legal;

  always_comb begin
    dec_sel     = SEL_AND;
    dec_use_imm = 1'b0;
    dec_legal   = 1'b0;
    case (opcode)
      OP_R: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: begin dec_sel = SEL_ADD; dec_legal = 1'b1; end
          {F7_ALT,  3'b000}: begin dec_sel = SEL_SUB; dec_legal = 1'b1; end
          {F7_BASE, 3'b111}: begin dec_sel = SEL_AND; dec_legal = 1'b1; end
          {F7_BASE, 3'b110}: begin dec_sel = SEL_OR;  dec_legal = 1'b1; end
          {F7_BASE, 3'b010}: begin dec_sel = SEL_SLT; dec_legal = 1'b1; end
          {F7_ALT,  3'b100}: begin dec_sel = SEL_NOR; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_I: begin
        // Immediate is only selected for legal encodings so that an illegal
        // I-type still presents rs2_val on b.
        case (funct3)
          3'b000: begin dec_sel = SEL_ADD; dec_use_imm = 1'b1; dec_legal = 1'b1; end
          3'b111: begin dec_sel = SEL_AND; dec_use_imm = 1'b1; dec_legal = 1'b1; end
          3'b110: begin dec_sel = SEL_OR;  dec_use_imm = 1'b1; dec_legal = 1'b1; end
          3'b010: begin dec_sel = SEL_SLT; dec_use_imm = 1'b1; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        // Address generation: rs1 + imm
        dec_sel     = SEL_ADD;
        dec_use_imm = 1'b1;
        dec_legal   = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec_sel   = SEL_EQ;
          dec_legal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Operands actually issued on accept
  logic [31:0] issue_a, issue_b;
  logic [3:0]  issue_sel;

  assign issue_sel = dec_legal ? dec_sel : SEL_AND;

`ifdef ALU_ISSUE_ILLEGAL_EN
  assign issue_a = dec_legal ? rs1_val : 32'd0;
  assign issue_b = dec_legal ? (dec_use_imm ? imm : rs2_val) : 32'd0;
`else
  assign issue_a = rs1_val;
  assign issue_b = dec_use_imm ? imm : rs2_val;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic accept;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Accept a new instruction on the same edge the result is taken,
        // which gives back-to-back issue every 2 cycles.
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // State already reads IDLE during reset; keep the source from seeing a
    // ready it cannot use until reset is released.
    if (rst) in_ready = 1'b0;
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Illegal tracking (optional)
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic pend_ill_reg;   // instruction in EXEC was illegal
  logic illegal_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ill_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      if (accept) pend_ill_reg <= ~dec_legal;
      if (state_reg == EXEC)
        illegal_reg <= pend_ill_reg;
      else if ((state_reg == DONE) && out_ready)
        illegal_reg <= 1'b0;
    end
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Operand issue and result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_reg    <= 32'd0;
      alu_b_reg    <= 32'd0;
      alu_sel_reg  <= SEL_AND;
      result_reg   <= 32'd0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      carry_reg    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_reg   <= issue_a;
        alu_b_reg   <= issue_b;
        alu_sel_reg <= issue_sel;
      end
      // Result registers only load in EXEC, so they stay frozen while the
      // consumer applies backpressure in DONE.
      if (state_reg == EXEC) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        if (pend_ill_reg) begin
          result_reg   <= 32'd0;
          zero_reg     <= 1'b1;
          overflow_reg <= 1'b0;
          carry_reg    <= 1'b0;
        end else begin
          result_reg   <= alu_out;
          zero_reg     <= alu_zero;
          overflow_reg <= alu_ovf;
          carry_reg    <= alu_cout;
        end
`else
        result_reg   <= alu_out;
        zero_reg     <= alu_zero;
        overflow_reg <= alu_ovf;
        carry_reg    <= alu_cout;
`endif
      end
    end
  end

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_sel  = alu_sel_reg;
  assign result   = result_reg;
  assign zero     = zero_reg;
  assign overflow = overflow_reg;
  assign carry    = carry_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. A behavioural 32-bit ALU responds
// to the registered operands; expected values come from a table of legal
// encodings plus plain arithmetic per operation.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero, alu_ovf, alu_cout;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, overflow, carry, illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .imm      (imm),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_ovf  (alu_ovf),
    .alu_cout (alu_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .carry    (carry),
    .illegal  (illegal)
  );

  // ---------------------------------------------------------------------------
  // Behavioural ALU and operation model
  // ---------------------------------------------------------------------------
  typedef enum {K_AND, K_OR, K_ADD, K_SUB, K_SLT, K_NOR, K_EQ} kind_t;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        c;
  } flags_t;

  function automatic flags_t alu_fn(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    flags_t      f;
    logic [32:0] s;
    f = '0;
    s = 33'd0;
    case (k)
      K_AND: f.r = a & b;
      K_OR:  f.r = a | b;
      K_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        f.r = s[31:0];
        f.c = s[32];
        f.o = (a[31] == b[31]) && (f.r[31] != a[31]);
      end
      K_SUB: begin
        f.r = a - b;
        f.o = (a[31] != b[31]) && (f.r[31] != a[31]);
      end
      K_SLT: f.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_NOR: f.r = ~(a | b);
      K_EQ:  f.r = (a == b) ? 32'd1 : 32'd0;
      default: f.r = 32'd0;
    endcase
    f.z = (f.r == 32'd0);
    return f;
  endfunction

  flags_t stub;
  always_comb begin
    kind_t k;
    k = K_AND;
    case (alu_sel)
      4'b0000: k = K_AND;
      4'b0001: k = K_OR;
      4'b0010: k = K_ADD;
      4'b0110: k = K_SUB;
      4'b0111: k = K_SLT;
      4'b1100: k = K_NOR;
      4'b1111: k = K_EQ;
      default: k = K_AND;
    endcase
    stub = alu_fn(k, alu_a, alu_b);
  end
  assign alu_out  = stub.r;
  assign alu_zero = stub.z;
  assign alu_ovf  = stub.o;
  assign alu_cout = stub.c;

  // Table of legal encodings
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    bit         f3_any;
    logic [6:0] f7;
    bit         f7_any;
    kind_t      k;
    logic [3:0] sel;
    bit         imm_b;
  } entry_t;

  localparam int NTBL = 13;
  entry_t tbl [NTBL];

  initial begin
    tbl[0]  = '{7'b0110011, 3'b000, 0, 7'b0000000, 0, K_ADD, 4'b0010, 0};
    tbl[1]  = '{7'b0110011, 3'b000, 0, 7'b0100000, 0, K_SUB, 4'b0110, 0};
    tbl[2]  = '{7'b0110011, 3'b111, 0, 7'b0000000, 0, K_AND, 4'b0000, 0};
    tbl[3]  = '{7'b0110011, 3'b110, 0, 7'b0000000, 0, K_OR,  4'b0001, 0};
    tbl[4]  = '{7'b0110011, 3'b010, 0, 7'b0000000, 0, K_SLT, 4'b0111, 0};
    tbl[5]  = '{7'b0110011, 3'b100, 0, 7'b0100000, 0, K_NOR, 4'b1100, 0};
    tbl[6]  = '{7'b0010011, 3'b000, 0, 7'b0000000, 1, K_ADD, 4'b0010, 1};
    tbl[7]  = '{7'b0010011, 3'b111, 0, 7'b0000000, 1, K_AND, 4'b0000, 1};
    tbl[8]  = '{7'b0010011, 3'b110, 0, 7'b0000000, 1, K_OR,  4'b0001, 1};
    tbl[9]  = '{7'b0010011, 3'b010, 0, 7'b0000000, 1, K_SLT, 4'b0111, 1};
    tbl[10] = '{7'b0000011, 3'b000, 1, 7'b0000000, 1, K_ADD, 4'b0010, 1};
    tbl[11] = '{7'b0100011, 3'b000, 1, 7'b0000000, 1, K_ADD, 4'b0010, 1};
    tbl[12] = '{7'b1100011, 3'b000, 0, 7'b0000000, 1, K_EQ,  4'b1111, 0};
  end

  function automatic int find_entry(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].op == op && (tbl[i].f3_any || tbl[i].f3 == f3) &&
          (tbl[i].f7_any || tbl[i].f7 == f7))
        return i;
    end
    return -1;
  endfunction

  // Expected values for the instruction currently being issued
  logic [3:0]  exp_sel;
  logic [31:0] exp_a, exp_b;
  flags_t      exp_f;
  logic        exp_ill;

  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    int idx;
    idx = find_entry(op, f3, f7);
    if (idx >= 0) begin
      exp_sel = tbl[idx].sel;
      exp_a   = r1;
      exp_b   = tbl[idx].imm_b ? im : r2;
      exp_f   = alu_fn(tbl[idx].k, exp_a, exp_b);
      exp_ill = 1'b0;
    end else begin
      exp_sel = 4'b0000;
`ifdef ALU_ISSUE_ILLEGAL_EN
      exp_a   = 32'd0;
      exp_b   = 32'd0;
      exp_f   = '{r: 32'd0, z: 1'b1, o: 1'b0, c: 1'b0};
      exp_ill = 1'b1;
`else
      exp_a   = r1;
      exp_b   = r2;
      exp_f   = alu_fn(K_AND, r1, r2);
      exp_ill = 1'b0;
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an instruction and hold it until accepted (bounded)
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_val = r1; rs2_val = r2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) break;
      tick();
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] obs_res;
  logic        obs_z, obs_o, obs_c, obs_ill;

  // Full transaction: issue, check operands, check result, stall, hand off
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                     input int stall);
    model(op, f3, f7, r1, r2, im);
    out_ready = 1'b0;
    send(op, f3, f7, r1, r2, im);
    chk("exec_sel", 32'(alu_sel), 32'(exp_sel));
    chk("exec_a", alu_a, exp_a);
    chk("exec_b", alu_b, exp_b);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    chk("exec_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("done_valid", 32'(out_valid), 32'd1);
    chk("result", result, exp_f.r);
    chk("zero", 32'(zero), 32'(exp_f.z));
    chk("overflow", 32'(overflow), 32'(exp_f.o));
    chk("carry", 32'(carry), 32'(exp_f.c));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    obs_res = result; obs_z = zero; obs_o = overflow; obs_c = carry; obs_ill = illegal;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", result, exp_f.r);
      chk("stall_flags", {28'd0, zero, overflow, carry, illegal},
          {28'd0, exp_f.z, exp_f.o, exp_f.c, exp_ill});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_valid", 32'(out_valid), 32'd0);
    chk("after_illegal", 32'(illegal), 32'd0);
    $display("txn op=%b f3=%b f7=%b rs1=%08h rs2=%08h imm=%08h -> res=%08h z=%b v=%b c=%b ill=%b",
             op, f3, f7, r1, r2, im, obs_res, obs_z, obs_o, obs_c, obs_ill);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    rs1_val = '0; rs2_val = '0; imm = '0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, zero, overflow, carry, illegal}, 32'd0);
    #10;
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // ADD 5 + 7
    run(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 0);
    chk("add_res", obs_res, 32'd12);
    chk("add_zero", 32'(obs_z), 32'd0);

    // SUB 0x80000000 - 1
    run(7'b0110011, 3'b000, 7'b0100000, 32'h8000_0000, 32'd1, 32'd0, 1);
    chk("sub_res", obs_res, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(obs_o), 32'd1);
    chk("sub_carry", 32'(obs_c), 32'd0);

    // BEQ equal / not equal
    run(7'b1100011, 3'b000, 7'b0000000, 32'h1234, 32'h1234, 32'd0, 0);
    chk("beq_eq_res", obs_res, 32'd1);
    chk("beq_eq_zero", 32'(obs_z), 32'd0);
    run(7'b1100011, 3'b000, 7'b0000000, 32'h1234, 32'h1235, 32'd0, 0);
    chk("beq_ne_res", obs_res, 32'd0);
    chk("beq_ne_zero", 32'(obs_z), 32'd1);

    // Backpressure: ADDI 10 + (-3), held 5 cycles, then queued OR on the
    // same edge that the result is taken
    out_ready = 1'b0;
    send(7'b0010011, 3'b000, 7'b0000000, 32'd10, 32'd0, 32'hFFFF_FFFD);
    chk("addi_sel", 32'(alu_sel), 32'b0010);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    opcode = 7'b0110011; funct3 = 3'b110; funct7 = 7'b0000000;
    rs1_val = 32'h0000_F0F0; rs2_val = 32'h0000_0FF0; imm = 32'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_pass_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("q_exec_sel", 32'(alu_sel), 32'b0001);
    chk("q_exec_valid", 32'(out_valid), 32'd0);
    tick();
    chk("q_done_valid", 32'(out_valid), 32'd1);
    chk("q_result", result, 32'h0000_FFF0);
    $display("txn queued OR rs1=0000f0f0 rs2=00000ff0 -> res=%08h", result);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in EXEC
    send(7'b0110011, 3'b000, 7'b0000000, 32'd100, 32'd23, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_alu_a", alu_a, 32'd0);
    chk("mrst_alu_b", alu_b, 32'd0);
    chk("mrst_alu_sel", 32'(alu_sel), 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_flags", {28'd0, zero, overflow, carry, illegal}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_no_valid", 32'(out_valid), 32'd0);
    end
    chk("mrst_resume_ready", 32'(in_ready), 32'd1);
    $display("txn reset during EXEC discarded");

    // Illegal opcode
    run(7'b1111111, 3'b000, 7'b0000000, 32'h0000_00F0, 32'h0000_003C, 32'd0, 1);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("ill_flag", 32'(obs_ill), 32'd1);
    chk("ill_res", obs_res, 32'd0);
    chk("ill_zero", 32'(obs_z), 32'd1);
`else
    chk("ill_flag", 32'(obs_ill), 32'd0);
    chk("ill_res", obs_res, 32'h0000_0030);
`endif

    // Randomized instructions
    for (int n = 0; n < 60; n++) begin
      logic [6:0]  op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] r1, r2, im;
      int          idx;
      int          mode;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          op = 7'b1111111; f3 = 3'($urandom); f7 = 7'($urandom);
        end else begin
          op = 7'b0110011; f3 = 3'b001; f7 = 7'($urandom);
        end
      end else begin
        idx = int'($urandom_range(0, NTBL - 1));
        op = tbl[idx].op;
        f3 = tbl[idx].f3_any ? 3'($urandom) : tbl[idx].f3;
        f7 = tbl[idx].f7_any ? 7'($urandom) : tbl[idx].f7;
      end
      mode = int'($urandom_range(0, 3));
      r1 = $urandom; r2 = $urandom; im = $urandom;
      case (mode)
        1: begin r1 = 32'($urandom_range(0, 15)); r2 = 32'($urandom_range(0, 15)); end
        2: r2 = r1;
        3: begin r1 = 32'h7FFF_FFFF; r2 = 32'h8000_0000; im = 32'd1; end
        default: ;
      endcase
      run(op, f3, f7, r1, r2, im, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
